// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between instruction fetch and the memory stage
// Grants, dm_err and the RAM strobes are combinational in IDLE; rvalid/done pulses are registered.
module mem_port_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [1:0]        dm_size,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   output logic              dm_done,
   output logic              dm_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_MERGE} state_t;

   state_t            state;
   logic [SW-1:0]     streak;
   logic [1:0]        rmw_lane;
   logic              rmw_half;
   logic [15:0]       rmw_data;
   logic [ADDR_W-1:0] rmw_addr;
   logic [31:0]       merged;

   logic dm_bad, idle_ok, starve, in_merge, word_store;

   assign dm_bad = (dm_size == 2'b11) ||
                   (dm_size == 2'b01 && dm_addr[0]) ||
                   (dm_size == 2'b10 && dm_addr[1:0] != 2'b00);

   assign idle_ok    = rst_n && (state == IDLE);
   assign in_merge   = rst_n && (state == RMW_MERGE);
   assign starve     = if_req && (streak == SW'(STARVE_LIMIT));
   assign word_store = dm_we && (dm_size == 2'b10);

   assign dm_err = idle_ok && dm_req && dm_bad;
   assign dm_gnt = idle_ok && dm_req && !dm_bad && !starve;
   assign if_gnt = idle_ok && if_req && !dm_gnt;

   assign ram_en    = dm_gnt || if_gnt || in_merge;
   assign ram_we    = (dm_gnt && word_store) || in_merge;
   assign ram_addr  = (state == RMW_MERGE) ? rmw_addr :
                      dm_gnt ? dm_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
   assign ram_wdata = (state == RMW_MERGE) ? merged : dm_wdata;

   // Read data is only meaningful during the rvalid cycle; elsewhere it reads as zero.
   assign if_rdata = if_rvalid ? ram_rdata : 32'h0;
   assign dm_rdata = dm_rvalid ? ram_rdata : 32'h0;

   always_comb begin
      merged = ram_rdata;
      if (rmw_half) begin
         if (rmw_lane[1]) merged[31:16] = rmw_data;
         else             merged[15:0]  = rmw_data;
      end else begin
         case (rmw_lane)
            2'd0:    merged[7:0]   = rmw_data[7:0];
            2'd1:    merged[15:8]  = rmw_data[7:0];
            2'd2:    merged[23:16] = rmw_data[7:0];
            default: merged[31:24] = rmw_data[7:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         streak    <= '0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         dm_done   <= 1'b0;
         rmw_lane  <= '0;
         rmw_half  <= 1'b0;
         rmw_data  <= '0;
         rmw_addr  <= '0;
      end else begin
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         dm_done   <= 1'b0;
         if (!if_req || if_gnt) streak <= '0;
         else if (dm_gnt)       streak <= streak + 1'b1;
         case (state)
            IDLE: begin
               if (if_gnt) begin
                  state     <= RD_WAIT;
                  if_rvalid <= 1'b1;
               end else if (dm_gnt) begin
                  if (!dm_we) begin
                     state     <= RD_WAIT;
                     dm_rvalid <= 1'b1;
                  end else if (word_store) begin
                     dm_done <= 1'b1;
                  end else begin
                     state    <= RMW_MERGE;
                     rmw_lane <= dm_addr[1:0];
                     rmw_half <= dm_size[0];
                     rmw_data <= dm_wdata[15:0];
                     rmw_addr <= dm_addr[ADDR_W+1:2];
                  end
               end
            end
            RD_WAIT: state <= IDLE;
            RMW_MERGE: begin
               state   <= IDLE;
               dm_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], dm_addr[31:ADDR_W+2]};

endmodule
